// File: rtl/gb_frame_ctrl_if.sv
// Bus bundle for gb_frame_ctrl: AXI-lite config write path, source and accelerator
// pixel streams, and the monitored result stream.
interface gb_frame_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic                  cfg_AWVALID;
    logic                  cfg_AWREADY;
    logic [ADDR_W-1:0]     cfg_AWADDR;
    logic                  cfg_WVALID;
    logic                  cfg_WREADY;
    logic [DATA_W-1:0]     cfg_WDATA;
    logic [DATA_W/8-1:0]   cfg_WSTRB;
    logic                  cfg_BVALID;
    logic                  cfg_BREADY;
    logic [1:0]            cfg_BRESP;
    logic [7:0]            src_TDATA;
    logic                  src_TVALID;
    logic                  src_TREADY;
    logic [7:0]            acc_TDATA;
    logic                  acc_TVALID;
    logic                  acc_TREADY;
    logic                  acc_TLAST;
    logic                  res_TVALID;
    logic                  res_TREADY;

    modport master (
        output cfg_AWVALID, cfg_AWADDR, cfg_WVALID, cfg_WDATA, cfg_WSTRB, cfg_BREADY,
        output src_TREADY, acc_TDATA, acc_TVALID, acc_TLAST,
        input  cfg_AWREADY, cfg_WREADY, cfg_BVALID, cfg_BRESP,
        input  src_TDATA, src_TVALID, acc_TREADY, res_TVALID, res_TREADY
    );

    modport slave (
        input  cfg_AWVALID, cfg_AWADDR, cfg_WVALID, cfg_WDATA, cfg_WSTRB, cfg_BREADY,
        input  src_TREADY, acc_TDATA, acc_TVALID, acc_TLAST,
        output cfg_AWREADY, cfg_WREADY, cfg_BVALID, cfg_BRESP,
        output src_TDATA, src_TVALID, acc_TREADY, res_TVALID, res_TREADY
    );
endinterface

// File: rtl/gb_frame_ctrl.sv
// Frame sequencer for the Gaussian-blur accelerator: kicks ap_start, gates one bounded
// input frame, counts result beats. Optional drain watchdog: GB_FRAME_CTRL_TIMEOUT_EN.
//
// state    | meaning
// S_IDLE   | waiting for start
// S_WR     | AXI-lite write of ap_start (AW and W independent)
// S_RESP   | waiting for write response
// S_STREAM | passing source pixels to the accelerator
// S_DRAIN  | input closed, waiting for remaining result beats
// S_DONE   | one-cycle done pulse
module gb_frame_ctrl #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32,
    parameter int IN_PIX      = 316224,
    parameter int OUT_PIX     = 307200,
    parameter int CNT_W       = 19,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic            ap_clk,
    input  logic            ap_rst_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            err,
    gb_frame_ctrl_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_WR, S_RESP, S_STREAM, S_DRAIN, S_DONE} state_t;

    localparam logic [CNT_W-1:0] IN_LAST = CNT_W'(IN_PIX - 1);
    localparam logic [CNT_W-1:0] OUT_LIM = CNT_W'(OUT_PIX);

    if (IN_PIX < 1 || OUT_PIX < 1 || IN_PIX > 2**CNT_W - 1 || OUT_PIX > 2**CNT_W - 1 ||
        TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_param_err
        $error("gb_frame_ctrl: illegal parameter combination");
    end

    state_t             state_q, state_d;
    logic               awvalid_q, awvalid_d;
    logic               wvalid_q, wvalid_d;
    logic               bready_q, bready_d;
    logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               acc_hs, res_hs;
`ifdef GB_FRAME_CTRL_TIMEOUT_EN
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);
    logic [15:0]        idle_cnt_q, idle_cnt_d;
`endif

    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        err_d     = err_q;
`ifdef GB_FRAME_CTRL_TIMEOUT_EN
        idle_cnt_d = '0;
`endif
        acc_hs = (state_q == S_STREAM) && bus.src_TVALID && bus.acc_TREADY;
        res_hs = ((state_q == S_STREAM) || (state_q == S_DRAIN)) &&
                 bus.res_TVALID && bus.res_TREADY;

        // Result count saturates; any beat beyond the frame is an overrun.
        if (res_hs) begin
            if (out_cnt_q == OUT_LIM) err_d = 1'b1;
            else                      out_cnt_d = out_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_WR;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    err_d     = 1'b0;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                end
            end
            S_WR: begin
                if (awvalid_q && bus.cfg_AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && bus.cfg_WREADY)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = S_RESP;
                    bready_d = 1'b1;
                end
            end
            S_RESP: begin
                if (bus.cfg_BVALID) begin
                    bready_d = 1'b0;
                    if (bus.cfg_BRESP == 2'b00) begin
                        state_d = S_STREAM;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_STREAM: begin
                if (acc_hs) begin
                    in_cnt_d = in_cnt_q + 1'b1;
                    if (in_cnt_q == IN_LAST) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_cnt_q == OUT_LIM) begin
                    state_d = S_DONE;
                end
`ifdef GB_FRAME_CTRL_TIMEOUT_EN
                else if (!res_hs) begin
                    idle_cnt_d = idle_cnt_q + 16'd1;
                    if (idle_cnt_d == TO_LIM) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q   <= S_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            err_q     <= err_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

`ifdef GB_FRAME_CTRL_TIMEOUT_EN
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) idle_cnt_q <= '0;
        else           idle_cnt_q <= idle_cnt_d;
    end
`endif

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

    assign bus.cfg_AWVALID = awvalid_q;
    assign bus.cfg_AWADDR  = ADDR_W'(0);
    assign bus.cfg_WVALID  = wvalid_q;
    assign bus.cfg_WDATA   = DATA_W'(1);
    assign bus.cfg_WSTRB   = {(DATA_W/8){1'b1}};
    assign bus.cfg_BREADY  = bready_q;

    // Pixel path is a pure combinational gate; no skid buffer.
    assign bus.acc_TDATA  = bus.src_TDATA;
    assign bus.acc_TVALID = (state_q == S_STREAM) && bus.src_TVALID;
    assign bus.src_TREADY = (state_q == S_STREAM) && bus.acc_TREADY;
    assign bus.acc_TLAST  = (state_q == S_STREAM) && (in_cnt_q == IN_LAST);
endmodule

// File: tb/tb_gb_frame_ctrl.sv
// Directed bench for gb_frame_ctrl with IN_PIX=16, OUT_PIX=4, TIMEOUT_CYC=32.
// Frame scenarios come from a vector table; reset and watchdog cases are hand-written.
module tb_gb_frame_ctrl;
    localparam int NPIX = 16;

    logic ap_clk = 1'b0;
    logic ap_rst_n;
    logic start;
    logic busy, done, err;

    gb_frame_ctrl_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    gb_frame_ctrl #(
        .ADDR_W(5), .DATA_W(32), .IN_PIX(NPIX), .OUT_PIX(4), .CNT_W(19), .TIMEOUT_CYC(32)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start),
        .busy(busy), .done(done), .err(err), .bus(bus)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        string      name;
        int         aw_rdy;
        int         w_rdy;
        logic [1:0] bresp;
        bit         toggle;
        int         res_beats;
        int         res_start;
        int         exp_beats;
        int         exp_err;
    } vec_t;

    vec_t vecs[5];
    int n_pass = 0, n_tot = 0;

    int r_aw_hs, r_w_hs, r_w_hs_cyc, r_addr_bad, r_bready_early, r_beats, r_tlast_cnt;
    int r_tlast_last, r_data_bad, r_leak, r_err_done, r_done_cyc, r_last_res_cyc;
    int r_err_at1, r_busy_at1, r_busy_after, r_done_after, r_timed_out;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic run_frame(input vec_t v);
        int res_sent;
        bit got_done;
        res_sent = 0; got_done = 0;
        r_aw_hs = 0; r_w_hs = 0; r_w_hs_cyc = -1; r_addr_bad = 0; r_bready_early = 0;
        r_beats = 0; r_tlast_cnt = 0; r_tlast_last = 0; r_data_bad = 0; r_leak = 0;
        r_err_done = -1; r_done_cyc = -1; r_last_res_cyc = -1; r_err_at1 = -1; r_busy_at1 = -1;
        for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
            bit res_on;
            @(negedge ap_clk);
            start               = (cyc == 0);
            bus.cfg_AWREADY     = (cyc >= v.aw_rdy);
            bus.cfg_WREADY      = (cyc >= v.w_rdy);
            bus.cfg_BVALID      = 1'b1;
            bus.cfg_BRESP       = v.bresp;
            bus.src_TVALID      = 1'b1;
            bus.src_TDATA       = 8'(cyc * 7 + 3);
            bus.acc_TREADY      = v.toggle ? cyc[0] : 1'b1;
            res_on              = (cyc >= v.res_start) && (res_sent < v.res_beats);
            bus.res_TVALID      = res_on;
            bus.res_TREADY      = res_on;
            #1;
            if (cyc == 1) begin r_err_at1 = int'(err); r_busy_at1 = int'(busy); end
            if (bus.cfg_AWVALID && bus.cfg_AWREADY) begin
                r_aw_hs++;
                if (bus.cfg_AWADDR != 5'h00) r_addr_bad++;
            end
            if (bus.cfg_WVALID && bus.cfg_WREADY) begin
                r_w_hs++;
                r_w_hs_cyc = cyc;
                if (bus.cfg_WDATA != 32'h1 || bus.cfg_WSTRB != 4'hf) r_addr_bad++;
            end
            if (bus.cfg_BREADY && (r_w_hs == 0 || r_w_hs_cyc == cyc)) r_bready_early++;
            if (r_beats >= NPIX && (bus.src_TREADY || bus.acc_TVALID)) r_leak++;
            if (bus.acc_TVALID && bus.acc_TREADY) begin
                r_beats++;
                if (bus.acc_TDATA != bus.src_TDATA) r_data_bad++;
                if (bus.acc_TLAST) begin
                    r_tlast_cnt++;
                    if (r_beats == NPIX) r_tlast_last = 1;
                end
            end
            if (res_on) begin res_sent++; r_last_res_cyc = cyc; end
            if (done) begin r_err_done = int'(err); r_done_cyc = cyc; got_done = 1; end
        end
        r_timed_out = got_done ? 0 : 1;
        // Still in DONE here: a start now must not launch a new frame.
        start = 1'b1;
        @(negedge ap_clk);
        start = 1'b0;
        bus.res_TVALID = 1'b0;
        bus.res_TREADY = 1'b0;
        #1;
        r_busy_after = int'(busy);
        r_done_after = int'(done);
    endtask

    task automatic check_frame(input vec_t v);
        int has_last;
        has_last = (v.exp_beats > 0) ? 1 : 0;
        chk({v.name, ".done_seen"},   r_timed_out, 0);
        chk({v.name, ".aw_hs"},       r_aw_hs, 1);
        chk({v.name, ".w_hs"},        r_w_hs, 1);
        chk({v.name, ".aw_w_values"}, r_addr_bad, 0);
        chk({v.name, ".resp_order"},  r_bready_early, 0);
        chk({v.name, ".acc_beats"},   r_beats, v.exp_beats);
        chk({v.name, ".tlast_cnt"},   r_tlast_cnt, has_last);
        chk({v.name, ".tlast_final"}, r_tlast_last, has_last);
        chk({v.name, ".tdata"},       r_data_bad, 0);
        chk({v.name, ".drain_leak"},  r_leak, 0);
        chk({v.name, ".err_at_done"}, r_err_done, v.exp_err);
        chk({v.name, ".err_cleared"}, r_err_at1, 0);
        chk({v.name, ".busy_run"},    r_busy_at1, 1);
        chk({v.name, ".busy_after"},  r_busy_after, 0);
        chk({v.name, ".done_pulse"},  r_done_after, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int beats;
        vec_t tv;
        vecs[0] = '{"basic",     1, 1, 2'b00, 1'b0, 4, 6,   NPIX, 0};
        vecs[1] = '{"aw_first",  1, 4, 2'b00, 1'b0, 4, 6,   NPIX, 0};
        vecs[2] = '{"bresp_err", 1, 1, 2'b10, 1'b0, 0, 100, 0,    1};
        vecs[3] = '{"toggle",    1, 1, 2'b00, 1'b1, 4, 40,  NPIX, 0};
        vecs[4] = '{"res_over",  1, 1, 2'b00, 1'b0, 5, 6,   NPIX, 1};

        ap_rst_n = 1'b0; start = 1'b0;
        bus.cfg_AWREADY = 1'b0; bus.cfg_WREADY = 1'b0; bus.cfg_BVALID = 1'b0;
        bus.cfg_BRESP = 2'b00; bus.src_TDATA = 8'h00; bus.src_TVALID = 1'b0;
        bus.acc_TREADY = 1'b0; bus.res_TVALID = 1'b0; bus.res_TREADY = 1'b0;
        repeat (3) @(negedge ap_clk);
        #1;
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.err", err, 0);
        chk("rst.valids", {bus.cfg_AWVALID, bus.cfg_WVALID, bus.cfg_BREADY,
                           bus.src_TREADY, bus.acc_TVALID}, 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i]);
            check_frame(vecs[i]);
        end

        // Reset in the middle of the pixel stream.
        @(negedge ap_clk);
        start = 1'b1;
        bus.cfg_AWREADY = 1'b1; bus.cfg_WREADY = 1'b1; bus.cfg_BVALID = 1'b1;
        bus.cfg_BRESP = 2'b00; bus.src_TVALID = 1'b1; bus.acc_TREADY = 1'b1;
        beats = 0;
        for (int c = 0; c < 50 && beats < 3; c++) begin
            @(negedge ap_clk);
            start = 1'b0;
            #1;
            if (bus.acc_TVALID && bus.acc_TREADY) beats++;
        end
        chk("mid_rst.beats_before", beats, 3);
        @(negedge ap_clk);
        ap_rst_n = 1'b0;
        @(posedge ap_clk);
        #1;
        chk("mid_rst.busy", busy, 0);
        chk("mid_rst.done_err", {done, err}, 0);
        chk("mid_rst.valids", {bus.cfg_AWVALID, bus.cfg_WVALID, bus.cfg_BREADY,
                               bus.src_TREADY, bus.acc_TVALID, bus.acc_TLAST}, 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        run_frame(vecs[0]);
        chk("post_rst.acc_beats", r_beats, NPIX);
        chk("post_rst.err", r_err_done, 0);

`ifdef GB_FRAME_CTRL_TIMEOUT_EN
        // Two result beats inside DRAIN, then silence: done rises 32 edges after the last beat.
        tv = '{"timeout", 1, 1, 2'b00, 1'b0, 2, 22, NPIX, 1};
        run_frame(tv);
        chk("timeout.err", r_err_done, 1);
        chk("timeout.delay", r_done_cyc - r_last_res_cyc, 33);
        chk("timeout.acc_beats", r_beats, NPIX);
`else
        tv = vecs[0];
`endif
        chk("final.idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
